// File: rtl/corr_pkg.sv
// Shared constants and saturating-add helpers for the lag correlator bank.
// Helpers work on 64-bit carriers, so accumulator widths up to 64 bits are supported.
package corr_pkg;

  localparam logic CORR_MODE_AUTO  = 1'b0;
  localparam logic CORR_MODE_CROSS = 1'b1;

  // Read-map offsets, added to NLAGS.
  localparam int unsigned OFS_CNT  = 0;
  localparam int unsigned OFS_SUMA = 1;
  localparam int unsigned OFS_SUMB = 2;
  localparam int unsigned OFS_STAT = 3;

  function automatic logic [64:0] sat_lim(input int unsigned w);
    return (65'd1 << w) - 65'd1;
  endfunction

  // a + b clamped to 2^w-1; operands must already fit in w bits.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = sat_lim(w);
    if (sum > lim) return lim[63:0];
    return sum[63:0];
  endfunction

  function automatic logic sat_hit(input logic [63:0] a, input logic [63:0] b,
                                   input int unsigned w);
    logic [64:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum > sat_lim(w);
  endfunction

endpackage

// File: rtl/corr_lag_cell.sv
// One lag channel: unsigned multiply of a and b, accumulated with saturation.
// sat_o pulses on any enabled update whose true sum exceeded the accumulator range.
module corr_lag_cell
  import corr_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [ACC_W-1:0]  acc_o,
  output logic              sat_o
);

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    acc_d;

  assign prod = (2*DATA_W)'(a_i) * (2*DATA_W)'(b_i);

  always_comb begin
    acc_d = acc_q;
    sat_o = 1'b0;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = ACC_W'(sat_add(64'(acc_q), 64'(prod), ACC_W));
      sat_o = sat_hit(64'(acc_q), 64'(prod), ACC_W);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/corr_lag_bank.sv
// Linear-lag auto/cross correlator bank with saturating accumulators,
// normalisation sums and a registered host read port.
module corr_lag_bank
  import corr_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NLAGS  = 16,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] corr_a_i,
  input  logic [DATA_W-1:0] corr_b_i,
  input  logic              corr_sig_i,
  input  logic              corr_run_i,
  input  logic              corr_mode_i,
  input  logic              corr_clr_i,
  input  logic              rd_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [ACC_W-1:0]  rd_data_o,
  output logic              rd_valid_o,
  output logic              ovf_o
);

  localparam logic [ADDR_W-1:0] ADDR_CNT  = ADDR_W'(NLAGS + OFS_CNT);
  localparam logic [ADDR_W-1:0] ADDR_SUMA = ADDR_W'(NLAGS + OFS_SUMA);
  localparam logic [ADDR_W-1:0] ADDR_SUMB = ADDR_W'(NLAGS + OFS_SUMB);
  localparam logic [ADDR_W-1:0] ADDR_STAT = ADDR_W'(NLAGS + OFS_STAT);

  logic              mode_q, mode_d;
  logic [ACC_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  sum_a_q, sum_a_d;
  logic [ACC_W-1:0]  sum_b_q, sum_b_d;
  logic              ovf_q, ovf_d;
  logic [ACC_W-1:0]  rd_data_q, rd_data_d;
  logic              rd_valid_q;
  logic [ACC_W-1:0]  rd_mux;

  // The oldest tap's previous value is never consumed, so only NLAGS-1 stages are stored.
  logic [DATA_W-1:0] dly_q [NLAGS-1];
  logic [DATA_W-1:0] dly_d [NLAGS-1];
  logic [DATA_W-1:0] dly_new [NLAGS];

  logic              accept;
  logic [DATA_W-1:0] b_eff;
  logic [ACC_W-1:0]  acc_w [NLAGS];
  logic [NLAGS-1:0]  sat_w;
  logic              ctr_sat;

  assign accept = corr_sig_i & corr_run_i & ~corr_clr_i;
  assign b_eff  = (mode_q == CORR_MODE_CROSS) ? corr_b_i : corr_a_i;

  always_comb begin
    dly_new[0] = b_eff;
    for (int k = 1; k < NLAGS; k++) dly_new[k] = dly_q[k-1];
    for (int k = 0; k < NLAGS - 1; k++) begin
      dly_d[k] = dly_q[k];
      if (corr_clr_i)  dly_d[k] = '0;
      else if (accept) dly_d[k] = dly_new[k];
    end
  end

  for (genvar g = 0; g < NLAGS; g++) begin : g_lag
    corr_lag_cell #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_cell (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (corr_clr_i),
      .en_i   (accept),
      .a_i    (corr_a_i),
      .b_i    (dly_new[g]),
      .acc_o  (acc_w[g]),
      .sat_o  (sat_w[g])
    );
  end

  always_comb begin
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    sum_a_d = sum_a_q;
    sum_b_d = sum_b_q;
    ovf_d   = ovf_q;
    ctr_sat = sat_hit(64'(cnt_q), 64'd1, ACC_W)
            | sat_hit(64'(sum_a_q), 64'(corr_a_i), ACC_W)
            | sat_hit(64'(sum_b_q), 64'(b_eff), ACC_W);
    if (corr_clr_i) begin
      mode_d  = corr_mode_i;
      cnt_d   = '0;
      sum_a_d = '0;
      sum_b_d = '0;
      ovf_d   = 1'b0;
    end else if (accept) begin
      cnt_d   = ACC_W'(sat_add(64'(cnt_q), 64'd1, ACC_W));
      sum_a_d = ACC_W'(sat_add(64'(sum_a_q), 64'(corr_a_i), ACC_W));
      sum_b_d = ACC_W'(sat_add(64'(sum_b_q), 64'(b_eff), ACC_W));
      if (ctr_sat || (|sat_w)) ovf_d = 1'b1;
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NLAGS; k++) begin
      if (rd_addr_i == ADDR_W'(k)) rd_mux = acc_w[k];
    end
    if (rd_addr_i == ADDR_CNT)  rd_mux = cnt_q;
    if (rd_addr_i == ADDR_SUMA) rd_mux = sum_a_q;
    if (rd_addr_i == ADDR_SUMB) rd_mux = sum_b_q;
    if (rd_addr_i == ADDR_STAT) rd_mux = {{(ACC_W-3){1'b0}}, ovf_q, corr_run_i, mode_q};
  end

  // A read in the clear cycle still captures the pre-clear value.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_i)            rd_data_d = rd_mux;
    else if (corr_clr_i) rd_data_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q     <= corr_mode_i;
      cnt_q      <= '0;
      sum_a_q    <= '0;
      sum_b_q    <= '0;
      ovf_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      for (int k = 0; k < NLAGS - 1; k++) dly_q[k] <= '0;
    end else begin
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      sum_a_q    <= sum_a_d;
      sum_b_q    <= sum_b_d;
      ovf_q      <= ovf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_i;
      for (int k = 0; k < NLAGS - 1; k++) dly_q[k] <= dly_d[k];
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign ovf_o      = ovf_q;

endmodule
